sigmoid_sched: RTL

//  Shares one fixed-latency sigmoid pipeline (FP32 in/out, valid_in/valid_out, no backpressure)

---
 rtl/sigmoid_sched_pkg.sv | 18 +
 rtl/sigmoid_sched_if.sv | 29 ++
 rtl/sigmoid_sched_rr_arbiter.sv | 36 +++
 rtl/sigmoid_sched.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sigmoid_sched_pkg.sv
// Shared definitions for the sigmoid scheduler and other users of the shared activation pipe.
// Holds default sizes, the tag-width helper and the default tag-pipe entry type.
package sigmoid_pkg;
  localparam int FP_W        = 32;
  localparam int SIG_LAT_DEF = 4;
  localparam int NUM_REQ_DEF = 4;

  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_W_DEF = tag_w(NUM_REQ_DEF);

  typedef struct packed {
    logic                 v;
    logic [TAG_W_DEF-1:0] tag;
  } tag_ent_t;
endpackage

// File: rtl/sigmoid_sched_if.sv
// Requester / activation-unit / response bundle of the sigmoid scheduler.
// master = requester and activation side, slave = the scheduler.
interface sigmoid_sched_if
  import sigmoid_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = FP_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_mask;
  logic                      sig_valid_in;
  logic [DATA_W-1:0]         sig_x;
  logic                      sig_valid_out;
  logic [DATA_W-1:0]         sig_f_x;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;

  modport master (
    output req_valid, req_data, req_mask, sig_valid_out, sig_f_x,
    input  req_ready, sig_valid_in, sig_x, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, req_mask, sig_valid_out, sig_f_x,
    output req_ready, sig_valid_in, sig_x, resp_valid, resp_data
  );
endinterface

// File: rtl/sigmoid_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past i_ptr and wraps modulo NUM_REQ.
// Reusable by any shared activation unit.
module rr_arbiter
  import sigmoid_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int TAG_W   = tag_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [TAG_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [TAG_W-1:0]   o_gnt_idx,
  output logic               o_any
);
  logic [TAG_W-1:0] w_idx;
  logic             w_hit;
  logic             w_found;

  // first eligible requester after the pointer wins
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    w_hit     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx        = TAG_W'((int'(i_ptr) + k) % NUM_REQ);
      w_hit        = ~w_found & i_req[w_idx];
      o_gnt[w_idx] = w_hit;
      o_gnt_idx    = w_hit ? w_idx : o_gnt_idx;
      w_found      = w_found | w_hit;
    end
  end

  assign o_any = w_found;
endmodule

// File: rtl/sigmoid_sched.sv
// Round-robin scheduler sharing one fixed-latency sigmoid pipe between NUM_REQ requesters.
// Define SIGM_SCHED_PERF_EN to add the perf_issued / perf_stall saturating counters.
module sigmoid_sched
  import sigmoid_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = FP_W,
  parameter int SIG_LAT = SIG_LAT_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  sigmoid_sched_if.slave bus,
  output logic           busy,
  output logic           err
`ifdef SIGM_SCHED_PERF_EN
  ,
  output logic [31:0]    perf_issued,
  output logic [31:0]    perf_stall
`endif
);
  localparam int TAG_W = tag_w(NUM_REQ);

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic               w_xfer;
  logic               w_inflight;
  ent_t               w_tail;

  logic [TAG_W-1:0]   r_ptr;
  logic [TAG_W-1:0]   r_tag;
  logic               r_sig_valid_in;
  logic [DATA_W-1:0]  r_sig_x;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0]  r_resp_data;
  logic               r_err;
  ent_t               r_pipe [SIG_LAT];

  assign w_elig = bus.req_valid & bus.req_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_xfer)
  );

  assign w_tail = r_pipe[SIG_LAT-1];

  // any valid entry in the tag pipe
  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < SIG_LAT; i++) begin
      w_inflight = w_inflight | r_pipe[i].v;
    end
  end

  // issue, tag tracking, response routing and sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr          <= TAG_W'(NUM_REQ - 1);
      r_tag          <= '0;
      r_sig_valid_in <= 1'b0;
      r_sig_x        <= '0;
      r_resp_valid   <= '0;
      r_resp_data    <= '0;
      r_err          <= 1'b0;
      for (int i = 0; i < SIG_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_sig_valid_in <= w_xfer;
      if (w_xfer) begin
        r_ptr   <= w_gnt_idx;
        r_tag   <= w_gnt_idx;
        r_sig_x <= bus.req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
      end
      // head captures the op entering the sigmoid; tail lines up with sig_valid_out
      r_pipe[0] <= '{v: r_sig_valid_in, tag: r_tag};
      for (int i = 1; i < SIG_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      if (w_tail.v && bus.sig_valid_out) begin
        r_resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_tail.tag;
        r_resp_data  <= bus.sig_f_x;
      end else begin
        r_resp_valid <= '0;
      end
      if (w_tail.v != bus.sig_valid_out) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready    = w_gnt;
  assign bus.sig_valid_in = r_sig_valid_in;
  assign bus.sig_x        = r_sig_x;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_data    = r_resp_data;
  assign busy             = r_sig_valid_in | w_inflight;
  assign err              = r_err;

`ifdef SIGM_SCHED_PERF_EN
  logic        w_multi;
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;

  assign w_multi = |(w_elig & (w_elig - {{(NUM_REQ-1){1'b0}}, 1'b1}));

  // saturating transfer and contention counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_issued <= 32'd0;
      r_perf_stall  <= 32'd0;
    end else begin
      if (w_xfer && (r_perf_issued != 32'hFFFF_FFFF)) begin
        r_perf_issued <= r_perf_issued + 32'd1;
      end
      if (w_multi && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif
endmodule
